queue_arbiter: RTL and testbench
================================

Name: queue_arbiter

Overview:
- Shares one RAM-queue port among NREQ requesters, each asking for push (add) or pop (remove).
- Sits between the requesters and the queue's control FSM. Drives that FSM's active/cmd inputs and watches its add/remove/signal_overflow/signal_underflow outputs to decide when each transaction completes.
- Round-robin grant; one transaction in flight at a time; per-requester ack with error status.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, queue data width
- TIMEOUT, 4, WAIT-state cycles allowed for queue status before an error completion (>=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request, level; held until ack
- req_cmd  in  NREQ  per-requester op: 1=push, 0=pop
- req_wdata  in  NREQ*DW  per-requester push data; slice i = bits [i*DW +: DW]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  valid with ack: overflow, underflow or timeout
- tmo  out  1  valid with ack: error was a timeout
- rdata  out  DW  pop data, valid with ack on a successful pop
- busy  out  1  transaction in flight (state != IDLE)
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- q_active  out  1  to queue FSM: request strobe
- q_cmd  out  1  to queue FSM: 1=add, 0=remove
- q_wdata  out  DW  to queue datapath: push data
- q_rdata  in  DW  from queue datapath: pop data
- q_add, q_remove, q_sig_ovf, q_sig_unf  in  1 each  queue FSM status outputs

Behaviour:
- Reset (async, takes effect immediately even mid-transaction):
  - state=IDLE
  - all outputs 0
  - rr pointer=0, timer=0
  - An in-flight transaction is dropped with no ack.
- State machine, one-hot or binary at implementer's choice:
  - IDLE: if any req, grant the first requester at or after (last_grant+1) mod NREQ. Latch id, cmd and wdata. Update grant_id. Go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): q_active=1, q_cmd=latched cmd, q_wdata=latched data. Go to WAIT; timer=0.
  - WAIT: q_active=0; q_cmd and q_wdata stay held.
    - q_sig_ovf or q_sig_unf: set err=1, tmo=0, go to RESP. Error status takes priority if it occurs together with q_add/q_remove.
    - Otherwise q_add or q_remove: set err=0. On q_remove, capture q_rdata into the rdata register. Go to RESP.
    - Otherwise timer++. When timer==TIMEOUT-1, set err=1, tmo=1, go to RESP.
  - RESP (1 cycle): ack[id]=1, err, tmo and rdata presented. Go to IDLE.
- Output timing:
  - ack, err, tmo and rdata are registered; err and tmo are valid only while ack is high.
  - rdata holds its last captured value otherwise.
  - A push leaves rdata unchanged.
- Latency:
  - Request seen in IDLE at cycle 0: q_active at cycle 1, queue status expected at cycle 2, ack at cycle 3.
  - Back-to-back throughput is one transaction per 4 cycles.
- Fairness: the rr pointer (last_grant) updates at grant. A requester that holds req after its ack is served after all other pending requesters.
- Req changes:
  - Deassertion before grant: the requester is simply not chosen.
  - Deassertion or cmd/data change after grant: ignored; the latched transaction completes and ack still pulses.
- Status pulses from the queue FSM arriving in IDLE, ISSUE or RESP are ignored.
- The arbiter holds no occupancy count; full/empty decisions belong solely to the queue FSM.

Test Plan:
- Single push: req=4'b0001, req_cmd[0]=1, wdata0=8'hA5; q_add pulses at cycle 2 -> q_active high only at cycle 1 with q_cmd=1, q_wdata=A5; ack=4'b0001 at cycle 3 with err=0.
- Pop with data: req[2]=1, cmd=0; q_remove at cycle 2 with q_rdata=8'h3C -> ack=4'b0100, err=0, rdata=3C at cycle 3.
- Round-robin: all four req held continuously, status always success -> grant order 0,1,2,3,0; acks spaced exactly 4 cycles apart.
- Overflow/underflow: q_sig_ovf at cycle 2 -> ack with err=1, tmo=0, rdata unchanged. Repeat with q_sig_ovf and q_add both high at cycle 2 -> err=1.
- Timeout: no status after ISSUE, TIMEOUT=4 -> ack at cycle 6 with err=1, tmo=1; next pending requester is then granted.
- Reset mid-transaction: rst_n low during WAIT -> all outputs 0 immediately, no ack. After release, a pending req[1] gets q_active 1 cycle after the first IDLE cycle, and grant starts from index 1 (pointer reset to 0, search begins at 1).

Source files
------------

// File: rtl/queue_arbiter_if.sv
// Requester and queue-FSM signal bundle for the queue arbiter.
// master: arbiter view; slave: requesters plus queue FSM view.
interface queue_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_cmd;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic               tmo;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic               q_active;
  logic               q_cmd;
  logic [DW-1:0]      q_wdata;
  logic [DW-1:0]      q_rdata;
  logic               q_add;
  logic               q_remove;
  logic               q_sig_ovf;
  logic               q_sig_unf;

  modport master (
    input  req, req_cmd, req_wdata,
    input  q_rdata, q_add, q_remove,
    input  q_sig_ovf, q_sig_unf,
    output ack, err, tmo, rdata,
    output busy, grant_id,
    output q_active, q_cmd, q_wdata
  );

  modport slave (
    output req, req_cmd, req_wdata,
    output q_rdata, q_add, q_remove,
    output q_sig_ovf, q_sig_unf,
    input  ack, err, tmo, rdata,
    input  busy, grant_id,
    input  q_active, q_cmd, q_wdata
  );
endinterface

// File: rtl/queue_arbiter.sv
// Round-robin arbiter sharing one queue port among NREQ requesters.
// One transaction in flight; ack carries err/tmo status and pop data.
module queue_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  queue_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [IW-1:0]   grant_q;
  logic            cmd_q;
  logic [DW-1:0]   wdata_q;
  logic [TW-1:0]   timer_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic            tmo_q;
  logic [DW-1:0]   rdata_q;

  logic            pick_vld;
  logic [IW-1:0]   pick_id;
  logic            st_err;
  logic            st_ok;
  logic            tmo_hit;

  // First requester at or after last_grant+1, wrapping.
  function automatic logic [IW:0] pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   last
  );
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last) + i) % NREQ;
      if (!res[IW] && r[j])
        res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  assign {pick_vld, pick_id} =
    pick(bus.req, grant_q);

  assign st_err  = bus.q_sig_ovf | bus.q_sig_unf;
  assign st_ok   = bus.q_add | bus.q_remove;
  assign tmo_hit = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_vld) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (st_err || st_ok || tmo_hit)
               state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      timer_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      unique case (state_q)
        IDLE: if (pick_vld) begin
          grant_q <= pick_id;
          cmd_q   <= bus.req_cmd[pick_id];
          wdata_q <= bus.req_wdata[int'(pick_id)*DW +: DW];
        end
        ISSUE: timer_q <= '0;
        WAIT: begin
          // Error status wins over a coincident add/remove.
          if (st_err) begin
            ack_q <= NREQ'(1) << grant_q;
            err_q <= 1'b1;
          end else if (st_ok) begin
            ack_q <= NREQ'(1) << grant_q;
            if (bus.q_remove)
              rdata_q <= bus.q_rdata;
          end else if (tmo_hit) begin
            ack_q <= NREQ'(1) << grant_q;
            err_q <= 1'b1;
            tmo_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.tmo      = tmo_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = grant_q;
  assign bus.q_active = (state_q == ISSUE);
  assign bus.q_cmd    = cmd_q;
  assign bus.q_wdata  = wdata_q;
endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: push, pop, round-robin,
// error status, timeout and asynchronous reset mid-transaction.
module tb_queue_arbiter;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  queue_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  queue_arbiter #(
    .NREQ(4), .DW(8), .TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req       = '0;
    bus.req_cmd   = '0;
    bus.req_wdata = '0;
    bus.q_rdata   = '0;
    bus.q_add     = 1'b0;
    bus.q_remove  = 1'b0;
    bus.q_sig_ovf = 1'b0;
    bus.q_sig_unf = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({bus.ack, bus.err, bus.tmo, bus.rdata,
         bus.busy, bus.grant_id, bus.q_active,
         bus.q_cmd, bus.q_wdata} !== '0)
      $display("FAIL reset_outs got ack=%b busy=%b qa=%b",
               bus.ack, bus.busy, bus.q_active);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_idle got busy=%b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_single_push();
    bus.req_cmd   = 4'b0001;
    bus.req_wdata = 32'h0000_00A5;
    bus.req       = 4'b0001;
    n_total++;
    if (bus.q_active !== 1'b0)
      $display("FAIL push_c0_qa got %b want 0", bus.q_active);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.q_active, bus.q_cmd, bus.q_wdata} !== {2'b11, 8'hA5})
      $display("FAIL push_issue got qa=%b cmd=%b wd=%h want 1 1 a5",
               bus.q_active, bus.q_cmd, bus.q_wdata);
    else n_pass++;
    n_total++;
    if ({bus.busy, bus.grant_id} !== 3'b100)
      $display("FAIL push_grant got busy=%b id=%0d want 1 0",
               bus.busy, bus.grant_id);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.q_active, bus.q_cmd} !== 2'b01)
      $display("FAIL push_wait got qa=%b cmd=%b want 0 1",
               bus.q_active, bus.q_cmd);
    else n_pass++;
    bus.q_add = 1'b1;
    tick();
    bus.q_add = 1'b0;
    n_total++;
    if ({bus.ack, bus.err} !== 5'b0001_0)
      $display("FAIL push_ack got ack=%b err=%b want 0001 0",
               bus.ack, bus.err);
    else n_pass++;
    bus.req = '0;
    tick();
    n_total++;
    if ({bus.ack, bus.busy} !== 5'b0)
      $display("FAIL push_done got ack=%b busy=%b want 0000 0",
               bus.ack, bus.busy);
    else n_pass++;
  endtask

  task automatic test_pop();
    bus.req_cmd = 4'b0000;
    bus.req     = 4'b0100;
    tick();
    n_total++;
    if ({bus.q_active, bus.q_cmd, bus.grant_id} !== 4'b10_10)
      $display("FAIL pop_issue got qa=%b cmd=%b id=%0d want 1 0 2",
               bus.q_active, bus.q_cmd, bus.grant_id);
    else n_pass++;
    tick();
    bus.q_remove = 1'b1;
    bus.q_rdata  = 8'h3C;
    tick();
    bus.q_remove = 1'b0;
    bus.q_rdata  = 8'h00;
    n_total++;
    if ({bus.ack, bus.err, bus.rdata} !== {4'b0100, 1'b0, 8'h3C})
      $display("FAIL pop_ack got ack=%b err=%b rd=%h want 0100 0 3c",
               bus.ack, bus.err, bus.rdata);
    else n_pass++;
    bus.req = '0;
    tick();
  endtask

  task automatic test_ovf_with_add();
    bus.req_cmd   = 4'b1000;
    bus.req_wdata = 32'h5A00_0000;
    bus.req       = 4'b1000;
    tick();
    tick();
    bus.q_sig_ovf = 1'b1;
    bus.q_add     = 1'b1;
    tick();
    bus.q_sig_ovf = 1'b0;
    bus.q_add     = 1'b0;
    n_total++;
    if ({bus.ack, bus.err, bus.tmo, bus.rdata} !==
        {4'b1000, 2'b10, 8'h3C})
      $display("FAIL ovfadd_ack got ack=%b err=%b tmo=%b rd=%h want 1000 1 0 3c",
               bus.ack, bus.err, bus.tmo, bus.rdata);
    else n_pass++;
    bus.req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    int         id;
    bus.req_cmd   = 4'b1111;
    bus.req_wdata = 32'h4433_2211;
    bus.q_add     = 1'b1;
    bus.req       = 4'b1111;
    for (int c = 1; c <= 19; c++) begin
      tick();
      id      = ((c - 1) / 4) % 4;
      exp_ack = (c % 4 == 3) ? (4'b0001 << id) : 4'b0000;
      n_total++;
      if (bus.ack !== exp_ack)
        $display("FAIL rr_ack c%0d got %b want %b",
                 c, bus.ack, exp_ack);
      else n_pass++;
      if (c % 4 == 1) begin
        n_total++;
        if ({bus.q_active, bus.grant_id, bus.q_wdata} !==
            {1'b1, 2'(id), 8'(8'h11 * (id + 1))})
          $display("FAIL rr_issue c%0d got qa=%b id=%0d wd=%h want 1 %0d",
                   c, bus.q_active, bus.grant_id, bus.q_wdata, id);
        else n_pass++;
      end
    end
    bus.req   = '0;
    bus.q_add = 1'b0;
    tick();
    n_total++;
    if ({bus.busy, bus.rdata} !== {1'b0, 8'h3C})
      $display("FAIL rr_end got busy=%b rd=%h want 0 3c",
               bus.busy, bus.rdata);
    else n_pass++;
  endtask

  task automatic test_ovf();
    bus.req_cmd   = 4'b0010;
    bus.req_wdata = 32'h0000_9900;
    bus.req       = 4'b0010;
    tick();
    tick();
    bus.q_sig_ovf = 1'b1;
    tick();
    bus.q_sig_ovf = 1'b0;
    n_total++;
    if ({bus.ack, bus.err, bus.tmo, bus.rdata} !==
        {4'b0010, 2'b10, 8'h3C})
      $display("FAIL ovf_ack got ack=%b err=%b tmo=%b rd=%h want 0010 1 0 3c",
               bus.ack, bus.err, bus.tmo, bus.rdata);
    else n_pass++;
    bus.req = '0;
    tick();
  endtask

  task automatic test_unf_with_remove();
    bus.req_cmd = 4'b0000;
    bus.req     = 4'b0100;
    tick();
    tick();
    bus.q_sig_unf = 1'b1;
    bus.q_remove  = 1'b1;
    bus.q_rdata   = 8'hFF;
    tick();
    bus.q_sig_unf = 1'b0;
    bus.q_remove  = 1'b0;
    bus.q_rdata   = 8'h00;
    n_total++;
    if ({bus.ack, bus.err, bus.tmo, bus.rdata} !==
        {4'b0100, 2'b10, 8'h3C})
      $display("FAIL unf_ack got ack=%b err=%b tmo=%b rd=%h want 0100 1 0 3c",
               bus.ack, bus.err, bus.tmo, bus.rdata);
    else n_pass++;
    bus.req = '0;
    tick();
  endtask

  task automatic test_timeout_and_reset();
    bus.req_cmd   = 4'b1000;
    bus.req_wdata = 32'h7700_0000;
    bus.req       = 4'b1010;
    tick();
    n_total++;
    if ({bus.q_active, bus.grant_id} !== 3'b1_11)
      $display("FAIL tmo_issue got qa=%b id=%0d want 1 3",
               bus.q_active, bus.grant_id);
    else n_pass++;
    for (int c = 2; c <= 5; c++) begin
      tick();
      n_total++;
      if (bus.ack !== 4'b0000)
        $display("FAIL tmo_wait c%0d got ack=%b want 0000",
                 c, bus.ack);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({bus.ack, bus.err, bus.tmo} !== 6'b1000_11)
      $display("FAIL tmo_ack got ack=%b err=%b tmo=%b want 1000 1 1",
               bus.ack, bus.err, bus.tmo);
    else n_pass++;
    bus.req = 4'b0010;
    tick();
    n_total++;
    if ({bus.ack, bus.err, bus.tmo, bus.q_active} !== 7'b0)
      $display("FAIL tmo_after got ack=%b err=%b tmo=%b qa=%b want all 0",
               bus.ack, bus.err, bus.tmo, bus.q_active);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.q_active, bus.grant_id} !== 3'b1_01)
      $display("FAIL tmo_next got qa=%b id=%0d want 1 1",
               bus.q_active, bus.grant_id);
    else n_pass++;
    tick();
    n_total++;
    if (bus.busy !== 1'b1)
      $display("FAIL rst_pre got busy=%b want 1", bus.busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.ack, bus.err, bus.tmo, bus.rdata,
         bus.busy, bus.grant_id, bus.q_active,
         bus.q_cmd, bus.q_wdata} !== '0)
      $display("FAIL rst_mid got ack=%b busy=%b id=%0d rd=%h want all 0",
               bus.ack, bus.busy, bus.grant_id, bus.rdata);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    n_total++;
    if ({bus.ack, bus.busy} !== 5'b0)
      $display("FAIL rst_idle got ack=%b busy=%b want 0000 0",
               bus.ack, bus.busy);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.q_active, bus.grant_id, bus.ack} !== 7'b1_01_0000)
      $display("FAIL rst_regrant got qa=%b id=%0d ack=%b want 1 1 0000",
               bus.q_active, bus.grant_id, bus.ack);
    else n_pass++;
    tick();
    bus.q_add = 1'b1;
    tick();
    bus.q_add = 1'b0;
    n_total++;
    if ({bus.ack, bus.err} !== 5'b0010_0)
      $display("FAIL rst_ack got ack=%b err=%b want 0010 0",
               bus.ack, bus.err);
    else n_pass++;
    bus.req = '0;
    tick();
    n_total++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_done got busy=%b want 0", bus.busy);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_push();
    test_pop();
    test_ovf_with_add();
    test_round_robin();
    test_ovf();
    test_unf_with_remove();
    test_timeout_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
